// File: rtl/mem_sched_pkg.sv
// Shared bus constants, FSM encoding and port-slice helper for mem_sched.
package mem_sched_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Bit offset of port i inside a flattened per-port bus of slice width w.
  function automatic int port_off(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/mem_sched_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
  parameter int NPORTS = 3,
  parameter int LW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [LW-1:0]     last,
  output logic [NPORTS-1:0] pick,
  output logic              found
);

  // Scan last+1, last+2, ... modulo NPORTS; the previous owner comes last.
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = (int'(last) + k) % NPORTS;
      if (!found && req[idx[LW-1:0]]) begin
        pick[idx[LW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Round-robin scheduler sharing one memory bus between NPORTS requesters,
// with a watchdog that terminates transactions the bus never completes.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int NPORTS  = 3,
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid,
  output logic [NPORTS-1:0]        req_ready,
  input  logic [NPORTS*BUS_AW-1:0] req_addr,
  input  logic [NPORTS*BUS_DW-1:0] req_wdata,
  input  logic [NPORTS*BUS_SW-1:0] req_wstrb,
  output logic [BUS_DW-1:0]        req_rdata,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [BUS_AW-1:0]        mem_addr,
  output logic [BUS_DW-1:0]        mem_wdata,
  output logic [BUS_SW-1:0]        mem_wstrb,
  input  logic [BUS_DW-1:0]        mem_rdata,
  output logic [NPORTS-1:0]        grant,
  output logic                     bus_err
);

  localparam int LW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  // Counter saturates here; a hit fires on the cycle that would count to TIMEOUT.
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic          WD_EN   = (TIMEOUT > 0);

  state_t            state, state_nxt;
  logic [NPORTS-1:0] grant_nxt;
  logic [LW-1:0]     gidx, gidx_nxt;
  logic [LW-1:0]     last, last_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              bus_err_nxt;

  logic [NPORTS-1:0] pick;
  logic              found;
  logic [LW-1:0]     pick_idx;

  logic [BUS_AW-1:0] g_addr;
  logic [BUS_DW-1:0] g_wdata;
  logic [BUS_SW-1:0] g_wstrb;
  logic              g_valid;
  logic              wd_hit;

  rr_pick #(
    .NPORTS (NPORTS),
    .LW     (LW)
  ) u_pick (
    .req   (req_valid),
    .last  (last),
    .pick  (pick),
    .found (found)
  );

  // Binary index of the picked port, remembered so 'last' can be updated at completion.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (pick[i]) pick_idx = LW'(i);
    end
  end

  // Select the granted port's request fields; all zero while nothing is granted.
  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_wstrb = '0;
    g_valid = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant[i]) begin
        g_addr  = req_addr[port_off(i, BUS_AW) +: BUS_AW];
        g_wdata = req_wdata[port_off(i, BUS_DW) +: BUS_DW];
        g_wstrb = req_wstrb[port_off(i, BUS_SW) +: BUS_SW];
        g_valid = req_valid[i];
      end
    end
  end

  assign wd_hit    = WD_EN && (state == ST_BUSY) && !mem_ready && g_valid && (cnt == TO_LAST);
  assign mem_addr  = g_addr;
  assign mem_wdata = g_wdata;
  assign mem_wstrb = g_wstrb;
  assign req_rdata = wd_hit ? '0 : mem_rdata;

  // Arbitration, completion, abort and watchdog decisions.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    gidx_nxt    = gidx;
    last_nxt    = last;
    cnt_nxt     = cnt;
    bus_err_nxt = bus_err;
    req_ready   = '0;
    mem_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_nxt = pick;
          gidx_nxt  = pick_idx;
          cnt_nxt   = '0;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mem_valid = g_valid;
        if (mem_ready) begin
          // Completion wins even if the requester dropped valid this cycle.
          req_ready = grant;
          last_nxt  = gidx;
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (!g_valid) begin
          // Requester withdrew: drop silently, it still counts as its turn.
          last_nxt  = gidx;
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (wd_hit) begin
          req_ready   = grant;
          bus_err_nxt = 1'b1;
          last_nxt    = gidx;
          grant_nxt   = '0;
          state_nxt   = ST_IDLE;
        end else if (cnt < TO_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset clears ownership so mem_valid drops at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      gidx    <= '0;
      last    <= LW'(NPORTS - 1);
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      gidx    <= gidx_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      bus_err <= bus_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: stimulus queues expected responses,
// a negedge monitor pops and compares on every req_ready pulse.
module tb_mem_sched;

  localparam int NP = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid, req_ready, grant;
  logic [NP*32-1:0]  req_addr, req_wdata;
  logic [NP*4-1:0]   req_wstrb;
  logic [31:0]       req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;
  logic              mem_valid, mem_ready, bus_err;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   passes = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   t0;

  mem_sched #(.NPORTS(NP), .TIMEOUT(8), .CW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_rdata (req_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .grant     (grant),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int port, input logic [31:0] rdata, input int at);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_addr[32*p +: 32]  = a;
    req_wdata[32*p +: 32] = d;
    req_wstrb[4*p +: 4]   = s;
  endtask

  // Monitor: every completion strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_ready: got req_ready=%b, expected none (cycle %0d)", req_ready, cyc);
      end else begin
        exp_t        e;
        logic [31:0] oh;
        e  = exp_q.pop_front();
        oh = 32'd1 << e.port;
        check("ready_port", 32'(req_ready), oh);
        check("ready_rdata", req_rdata, e.rdata);
        check("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    for (int p = 0; p < NP; p++) set_port(p, 32'h1000 + 32'(p), 32'hFFFF0000, 4'hF);

    // Reset state with every port requesting
    @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    req_valid = '0;
    tick();
    rst = 1'b1;

    // Fairness: all ports busy, memory always ready
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A50001;
    t0 = cyc;
    req_valid = 3'b111;
    for (int j = 0; j < 6; j++) expect_rsp(j % 3, 32'hA5A50001, t0 + 1 + 2 * j);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("fair_idle_grant", 32'(grant), 32'd0);
      @(negedge clk);
      check("fair_grant", 32'(grant), 32'd1 << (j % 3));
    end
    tick();
    req_valid = '0;

    // Single port read
    mem_rdata = 32'hDEADBEEF;
    set_port(1, 32'h100, 32'h0, 4'h0);
    t0 = cyc;
    req_valid = 3'b010;
    expect_rsp(1, 32'hDEADBEEF, t0 + 1);
    @(negedge clk);
    check("single_arb_grant", 32'(grant), 32'd0);
    check("single_arb_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    check("single_grant", 32'(grant), 32'b010);
    check("single_valid", 32'(mem_valid), 32'd1);
    check("single_addr", mem_addr, 32'h100);
    check("single_wstrb", 32'(mem_wstrb), 32'd0);
    tick();
    req_valid = '0;

    // Write mux held across wait states
    mem_ready = 1'b0;
    mem_rdata = 32'h12345678;
    set_port(2, 32'h2004, 32'h55AA00FF, 4'b0011);
    req_valid = 3'b100;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check("wr_valid", 32'(mem_valid), 32'd1);
      check("wr_grant", 32'(grant), 32'b100);
      check("wr_addr", mem_addr, 32'h2004);
      check("wr_wdata", mem_wdata, 32'h55AA00FF);
      check("wr_wstrb", 32'(mem_wstrb), 32'b0011);
    end
    tick();
    mem_ready = 1'b1;
    expect_rsp(2, 32'h12345678, cyc);
    @(negedge clk);
    check("wr_addr_last", mem_addr, 32'h2004);
    check("wr_wdata_last", mem_wdata, 32'h55AA00FF);
    tick();
    req_valid = '0;

    // Abort: port0 withdraws in its 3rd bus cycle, port1 waiting
    mem_ready = 1'b0;
    set_port(0, 32'h300, 32'h0, 4'h0);
    set_port(1, 32'h400, 32'h0, 4'h0);
    req_valid = 3'b011;
    @(negedge clk);
    @(negedge clk);
    check("abort_first_grant", 32'(grant), 32'b001);
    tick();
    tick();
    req_valid = 3'b010;
    @(negedge clk);
    check("abort_mem_valid", 32'(mem_valid), 32'd0);
    check("abort_no_ready", 32'(req_ready), 32'd0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    expect_rsp(1, 32'hCAFEF00D, cyc + 1);
    @(negedge clk);
    check("abort_idle_grant", 32'(grant), 32'd0);
    @(negedge clk);
    check("abort_next_grant", 32'(grant), 32'b010);
    tick();
    req_valid = '0;

    // Watchdog: port0, memory never answers
    mem_ready = 1'b0;
    mem_rdata = 32'hBADBAD00;
    t0 = cyc;
    req_valid = 3'b001;
    expect_rsp(0, 32'h0, t0 + 8);
    repeat (8) @(negedge clk);
    check("wd_err_before", 32'(bus_err), 32'd0);
    check("wd_valid_before", 32'(mem_valid), 32'd1);
    @(negedge clk);
    check("wd_rdata_forced", req_rdata, 32'h0);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("wd_err_set", 32'(bus_err), 32'd1);
    check("wd_grant_idle", 32'(grant), 32'd0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h600DF00D;
    req_valid = 3'b010;
    expect_rsp(1, 32'h600DF00D, cyc + 1);
    @(negedge clk);
    @(negedge clk);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("wd_err_sticky", 32'(bus_err), 32'd1);

    // Asynchronous reset in the middle of a transaction
    tick();
    mem_ready = 1'b0;
    req_valid = 3'b100;
    @(negedge clk);
    @(negedge clk);
    check("areset_busy_valid", 32'(mem_valid), 32'd1);
    check("areset_busy_grant", 32'(grant), 32'b100);
    #2;
    rst = 1'b0;
    #1;
    check("areset_mem_valid", 32'(mem_valid), 32'd0);
    check("areset_grant", 32'(grant), 32'd0);
    check("areset_req_ready", 32'(req_ready), 32'd0);
    check("areset_mem_addr", mem_addr, 32'd0);
    check("areset_bus_err", 32'(bus_err), 32'd0);
    tick();
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADCAFE;
    req_valid = 3'b111;
    expect_rsp(0, 32'h0BADCAFE, cyc + 1);
    @(negedge clk);
    @(negedge clk);
    check("areset_first_grant", 32'(grant), 32'b001);
    tick();
    req_valid = '0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
